apb_slave_mem_ws: RTL

// - Parametrised APB slave: register-file memory, programmable wait states, PSLVERR on bad address.
// - Successor to the fixed 8-bit/64-entry APB slave. Sits behind the APB master / decoder on the PCLK domain.
// - Targets are test memories and peripheral register banks.

---
 rtl/apb_slave_mem_ws.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem_ws.sv
// APB register-file slave with programmable wait states and PSLVERR on out-of-range index; APB_SLV_PSTRB_EN adds byte strobes.
// Latency: PREADY rises on access cycle WAIT_STATES+1 (transfer = WAIT_STATES+2 cycles); PRDATA/PREADY/PSLVERR are registered.
// Backpressure: PREADY held low for WAIT_STATES access cycles; PSEL dropping in ACCESS aborts with no side effects.
module apb_slave_mem_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              write;
    logic              err;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pready_d, pslverr_d;
  logic [DATA_W-1:0] prdata_d;
  logic              start;
  logic              mem_we;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word, cur_word, wr_word;
  logic [IDX_W-1:0]  setup_idx, rd_idx;
  logic [STRB_W-1:0] strb_in;
  logic              setup_err;
  logic              unused_bits;

  function automatic logic idx_bad(input logic [IDX_W-1:0] i);
    return {1'b0, i} >= (IDX_W+1)'(DEPTH);
  endfunction

  assign setup_idx = PADDR[ADDR_W-1:ADDR_LSB];

`ifdef APB_SLV_PSTRB_EN
  assign strb_in   = PSTRB;
  // A read carrying strobes is a protocol error, reported like a bad address.
  assign setup_err = idx_bad(setup_idx) || (!PWRITE && (PSTRB != '0));
`else
  assign strb_in   = '1;
  assign setup_err = idx_bad(setup_idx);
`endif

  // With no wait states the read data is captured on the setup edge, before idx is latched.
  assign rd_idx   = (WAIT_STATES == 0) ? setup_idx : req_q.idx;
  assign rd_word  = mem[rd_idx[MEM_AW-1:0]];
  assign cur_word = mem[req_q.idx[MEM_AW-1:0]];

  assign unused_bits = ^{PADDR, rd_idx, req_q.idx};

  always_comb begin
    wr_word = cur_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (req_q.strb[b]) wr_word[8*b +: 8] = req_q.wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    pready_d  = PREADY;
    pslverr_d = PSLVERR;
    prdata_d  = PRDATA;
    mem_we    = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: start = PSEL && !PENABLE;
      ACCESS: begin
        if (PSEL && PENABLE) begin
          if (PREADY) begin
            mem_we    = req_q.write && !req_q.err;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_d  = 1'b1;
              pslverr_d = req_q.err;
              prdata_d  = (!req_q.write && !req_q.err) ? rd_word : '0;
            end
          end
        end else begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          state_d   = IDLE;
          start     = PSEL && !PENABLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      req_d.idx   = setup_idx;
      req_d.write = PWRITE;
      req_d.err   = setup_err;
      req_d.strb  = strb_in;
      req_d.wdata = PWDATA;
      cnt_d       = 4'(WAIT_STATES);
      state_d     = ACCESS;
      if (WAIT_STATES == 0) begin
        pready_d  = 1'b1;
        pslverr_d = setup_err;
        prdata_d  = (!PWRITE && !setup_err) ? rd_word : '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
      PRDATA  <= prdata_d;
    end
  end

  // Storage is deliberately outside reset so contents survive PRESETn.
  always_ff @(posedge PCLK) begin
    if (mem_we) mem[req_q.idx[MEM_AW-1:0]] <= wr_word;
  end

endmodule
